// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
//   - funct3 opcode values for the M extension
//   - FSM state encoding
//   - opcode classification helpers (divide family, operand signedness)
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Divide/remainder family
    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    // rs1 treated as two's complement
    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 treated as two's complement
    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on unsigned magnitudes, purely combinational.
//   div_i   : 1 = restoring divide step, 0 = shift-add multiply step
//   hi_i    : accumulator high half (product high / partial remainder)
//   lo_i    : accumulator low half (multiplier bits / dividend->quotient bits)
//   m_i     : multiplicand (multiply) or divisor (divide)
//   hi_c_o  : next high half
//   lo_c_o  : next low half
module muldiv_step #(
    parameter int unsigned W = 32
) (
    input  logic         div_i,
    input  logic [W-1:0] hi_i,
    input  logic [W-1:0] lo_i,
    input  logic [W-1:0] m_i,
    output logic [W-1:0] hi_c_o,
    output logic [W-1:0] lo_c_o
);

    logic [W:0]   sum_c;
    logic [W:0]   shifted_c;
    logic         ge_c;
    logic [W-1:0] div_hi_c;

    // Multiply: add multiplicand when the current multiplier bit is set, then shift the
    // whole {carry, hi, lo} right by one so the product grows into hi from the top.
    assign sum_c = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);

    // Divide: shift the next dividend bit into the remainder and trial-subtract.
    // The shifted remainder needs W+1 bits; the result after subtraction fits in W.
    assign shifted_c = {hi_i, lo_i[W-1]};
    assign ge_c      = (shifted_c >= {1'b0, m_i});
    assign div_hi_c  = ge_c ? (shifted_c[W-1:0] - m_i) : shifted_c[W-1:0];

    always_comb begin
        hi_c_o = sum_c[W:1];
        lo_c_o = {sum_c[0], lo_i[W-1:1]};
        if (div_i) begin
            hi_c_o = div_hi_c;
            lo_c_o = {lo_i[W-2:0], ge_c};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//   clk, rst (sync, active-low)
//   flush            : abandon the in-flight operation
//   in_valid/in_ready: operation handshake (op = funct3, a = rs1, b = rs2)
//   out_valid/out_ready/result: registered result handshake
// Magnitudes are iterated W times, then a fix-up cycle restores signs. Divide by zero and
// signed overflow bypass the iteration and complete one cycle after acceptance.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result
);

    localparam int unsigned CW = $clog2(W);
    localparam int unsigned PW = 2 * W;
    localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

    state_e       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d, result_q, result_d;
    logic [2:0]   op_q, op_d;
    logic         sa_q, sa_d, sb_q, sb_d;
    logic         in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    // Operand sign/magnitude at acceptance
    logic         sgn_a_c, sgn_b_c, dbz_c, ovf_c;
    logic [W-1:0] mag_a_c, mag_b_c;

    assign sgn_a_c = is_signed_a(op) & a[W-1];
    assign sgn_b_c = is_signed_b(op) & b[W-1];
    assign mag_a_c = sgn_a_c ? (~a + W'(1)) : a;
    assign mag_b_c = sgn_b_c ? (~b + W'(1)) : b;
    assign dbz_c   = is_div(op) && (b == '0);
    // Only signed DIV/REM (op[0]==0 within the divide family) can overflow
    assign ovf_c   = is_div(op) && !op[0] && (a == MIN_INT) && (b == '1);

    // Single iteration datapath
    logic         div_q_c;
    logic [W-1:0] step_hi_c, step_lo_c;

    assign div_q_c = is_div(op_q);

    muldiv_step #(.W(W)) u_step (
        .div_i  (div_q_c),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .m_i    (m_q),
        .hi_c_o (step_hi_c),
        .lo_c_o (step_lo_c)
    );

    // Sign fix-up: product/quotient negative when signs differ, remainder follows dividend
    logic           neg_c;
    logic [PW-1:0]  prod_c, prod_s_c;
    logic [W-1:0]   quo_s_c, rem_s_c, fix_c;

    assign neg_c    = sa_q ^ sb_q;
    assign prod_c   = {hi_q, lo_q};
    assign prod_s_c = neg_c ? (~prod_c + PW'(1)) : prod_c;
    assign quo_s_c  = neg_c ? (~lo_q + W'(1)) : lo_q;
    assign rem_s_c  = sa_q ? (~hi_q + W'(1)) : hi_q;

    always_comb begin
        fix_c = '0;
        case (op_q)
            OP_MUL:                       fix_c = prod_s_c[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_c = prod_s_c[PW-1:W];
            OP_DIV, OP_DIVU:              fix_c = quo_s_c;
            default:                      fix_c = rem_s_c;
        endcase
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        m_d      = m_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    op_d  = op;
                    sa_d  = sgn_a_c;
                    sb_d  = sgn_b_c;
                    hi_d  = '0;
                    cnt_d = CW'(W - 1);
                    // Multiply iterates over b's bits; divide shifts a's bits out
                    if (is_div(op)) begin
                        m_d  = mag_b_c;
                        lo_d = mag_a_c;
                    end else begin
                        m_d  = mag_a_c;
                        lo_d = mag_b_c;
                    end
                    if (dbz_c) begin
                        state_d  = ST_DONE;
                        result_d = op[1] ? a : '1;
                    end else if (ovf_c) begin
                        state_d  = ST_DONE;
                        result_d = op[1] ? '0 : MIN_INT;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                hi_d = step_hi_c;
                lo_d = step_lo_c;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_FIX: begin
                result_d = fix_c;
                state_d  = ST_DONE;
            end
            default: begin
                if (out_ready) begin
                    state_d  = ST_IDLE;
                    result_d = '0;
                end
            end
        endcase

        if (flush) begin
            state_d  = ST_IDLE;
            result_d = '0;
        end

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            m_q         <= '0;
            op_q        <= OP_MUL;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            m_q         <= m_d;
            op_q        <= op_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule
